// File: rtl/digital_sine_top.sv
// digital_sine_top: table-driven sine generator with two selectable rates.
// A divider paces a phase counter that walks a 256-entry, 12-bit sine ROM.
// The registered output is unsigned offset binary, centred on 2048.
// Optional feature macro: SINE_SW_SYNC_EN adds a 2-flop synchronizer on sw0.
module digital_sine_top #(
  parameter int unsigned cntampl_value_p = 8'hFF,
  parameter int          depth_p         = 8,
  parameter int          width_p         = 12
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               sw0,
  input  logic [7:0]         div_factor_freqhigh,
  input  logic [7:0]         div_factor_freqlow,
  output logic [width_p-1:0] sine_out
);

  logic                sw0_eff;
  logic [7:0]          thr;
  logic [7:0]          div_cnt_reg;
  logic                tick;
  logic [depth_p-1:0]  phase_reg;
  logic [7:0]          lut_addr;
  logic [6:0]          quarter_addr;
  logic [10:0]         quarter_val;
  logic [11:0]         lut_val;
  logic [width_p-1:0]  sine_out_reg;

`ifdef SINE_SW_SYNC_EN
  logic sw0_meta_reg;
  logic sw0_sync_reg;

  // Two-flop synchronizer: the board switch is asynchronous to clk_in.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sw0_meta_reg <= 1'b0;
      sw0_sync_reg <= 1'b0;
    end else begin
      sw0_meta_reg <= sw0;
      sw0_sync_reg <= sw0_meta_reg;
    end
  end

  assign sw0_eff = sw0_sync_reg;
`else
  assign sw0_eff = sw0;
`endif

  // '>=' rather than '==' so a threshold lowered below the running count
  // still produces a tick on the very next compare.
  assign thr  = sw0_eff ? div_factor_freqhigh : div_factor_freqlow;
  assign tick = (div_cnt_reg >= thr);

  // Divider: count up to the selected threshold, then clear and tick.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg <= 8'd0;
    end else if (tick) begin
      div_cnt_reg <= 8'd0;
    end else begin
      div_cnt_reg <= div_cnt_reg + 8'd1;
    end
  end

  // Phase counter: advance one sample per tick, wrapping at the table end.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      phase_reg <= '0;
    end else if (tick) begin
      if (phase_reg == depth_p'(cntampl_value_p)) begin
        phase_reg <= '0;
      end else begin
        phase_reg <= phase_reg + depth_p'(1);
      end
    end
  end

  // The ROM always spans one full period in 256 steps; map phase onto it.
  generate
    if (depth_p >= 8) begin : g_addr_trunc
      assign lut_addr = phase_reg[depth_p-1 -: 8];
    end else begin : g_addr_pad
      assign lut_addr = {phase_reg, {(8-depth_p){1'b0}}};
    end
  endgenerate

  // Quarter-wave symmetry: the rising quarter is stored, the second quarter
  // reads it mirrored, and the lower half subtracts it from mid-scale.
  assign quarter_addr = lut_addr[6] ? (7'd64 - {1'b0, lut_addr[5:0]})
                                    : {1'b0, lut_addr[5:0]};

  // Quarter ROM: round(2047 * sin(pi*k/128)) for k = 0..64.
  always_comb begin
    quarter_val = 11'd0;
    case (quarter_addr)
      7'd0:  quarter_val = 11'd0;    7'd1:  quarter_val = 11'd50;   7'd2:  quarter_val = 11'd100;  7'd3:  quarter_val = 11'd151;
      7'd4:  quarter_val = 11'd201;  7'd5:  quarter_val = 11'd251;  7'd6:  quarter_val = 11'd300;  7'd7:  quarter_val = 11'd350;
      7'd8:  quarter_val = 11'd399;  7'd9:  quarter_val = 11'd449;  7'd10: quarter_val = 11'd497;  7'd11: quarter_val = 11'd546;
      7'd12: quarter_val = 11'd594;  7'd13: quarter_val = 11'd642;  7'd14: quarter_val = 11'd690;  7'd15: quarter_val = 11'd737;
      7'd16: quarter_val = 11'd783;  7'd17: quarter_val = 11'd830;  7'd18: quarter_val = 11'd875;  7'd19: quarter_val = 11'd920;
      7'd20: quarter_val = 11'd965;  7'd21: quarter_val = 11'd1009; 7'd22: quarter_val = 11'd1052; 7'd23: quarter_val = 11'd1095;
      7'd24: quarter_val = 11'd1137; 7'd25: quarter_val = 11'd1179; 7'd26: quarter_val = 11'd1219; 7'd27: quarter_val = 11'd1259;
      7'd28: quarter_val = 11'd1299; 7'd29: quarter_val = 11'd1337; 7'd30: quarter_val = 11'd1375; 7'd31: quarter_val = 11'd1411;
      7'd32: quarter_val = 11'd1447; 7'd33: quarter_val = 11'd1483; 7'd34: quarter_val = 11'd1517; 7'd35: quarter_val = 11'd1550;
      7'd36: quarter_val = 11'd1582; 7'd37: quarter_val = 11'd1614; 7'd38: quarter_val = 11'd1644; 7'd39: quarter_val = 11'd1674;
      7'd40: quarter_val = 11'd1702; 7'd41: quarter_val = 11'd1729; 7'd42: quarter_val = 11'd1756; 7'd43: quarter_val = 11'd1781;
      7'd44: quarter_val = 11'd1805; 7'd45: quarter_val = 11'd1828; 7'd46: quarter_val = 11'd1850; 7'd47: quarter_val = 11'd1871;
      7'd48: quarter_val = 11'd1891; 7'd49: quarter_val = 11'd1910; 7'd50: quarter_val = 11'd1927; 7'd51: quarter_val = 11'd1944;
      7'd52: quarter_val = 11'd1959; 7'd53: quarter_val = 11'd1973; 7'd54: quarter_val = 11'd1986; 7'd55: quarter_val = 11'd1997;
      7'd56: quarter_val = 11'd2008; 7'd57: quarter_val = 11'd2017; 7'd58: quarter_val = 11'd2025; 7'd59: quarter_val = 11'd2032;
      7'd60: quarter_val = 11'd2037; 7'd61: quarter_val = 11'd2041; 7'd62: quarter_val = 11'd2045; 7'd63: quarter_val = 11'd2046;
      7'd64: quarter_val = 11'd2047;
      default: quarter_val = 11'd0;
    endcase
  end

  assign lut_val = lut_addr[7] ? (12'd2048 - {1'b0, quarter_val})
                               : (12'd2048 + {1'b0, quarter_val});

  // Output register: one clock behind the phase counter.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sine_out_reg <= width_p'(12'd2048);
    end else begin
      sine_out_reg <= width_p'(lut_val);
    end
  end

  assign sine_out = sine_out_reg;

endmodule

// File: tb/tb_digital_sine_top.sv
// Scoreboard bench for digital_sine_top (default build, sw0 used directly).
// Stimulus predicts each output sample (value and clock edge) from the
// sine formula and the divider timing rules; a monitor pops and compares
// every time sine_out changes.
module tb_digital_sine_top;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        sw0;
  logic [7:0]  div_factor_freqhigh;
  logic [7:0]  div_factor_freqlow;
  logic [11:0] sine_out;

  typedef struct {
    int edge_no;
    int value;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   edge_cnt = 0;
  int   m_cnt    = 0;
  int   m_phase  = 0;
  int   obs_max  = 0;
  int   obs_min  = 4096;

  digital_sine_top dut (
    .clk_in              (clk_in),
    .rst_n               (rst_n),
    .sw0                 (sw0),
    .div_factor_freqhigh (div_factor_freqhigh),
    .div_factor_freqlow  (div_factor_freqlow),
    .sine_out            (sine_out)
  );

  always #10 clk_in = ~clk_in;

  always @(posedge clk_in) edge_cnt <= edge_cnt + 1;

  function automatic int lut_ref(input int idx);
    real ang;
    real v;
    ang = 2.0 * 3.14159265358979323846 * real'(idx) / 256.0;
    v   = 2048.0 + 2047.0 * $sin(ang);
    return int'($floor(v + 0.5));
  endfunction

  // Monitor: every change of sine_out is one transaction.
  initial begin
    exp_t        e;
    logic [11:0] prev_out;
    prev_out = 12'd2048;
    forever begin
      @(negedge clk_in);
      if (!rst_n) begin
        checks++;
        if (sine_out !== 12'd2048) begin
          errors++;
          $display("FAIL reset_hold: sine_out=%0d required 2048", sine_out);
        end
        prev_out = sine_out;
      end else begin
        if (sine_out !== prev_out) begin
          if (int'(sine_out) > obs_max) obs_max = int'(sine_out);
          if (int'(sine_out) < obs_min) obs_min = int'(sine_out);
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change: sine_out=%0d at edge %0d, none required", sine_out, edge_cnt);
          end else begin
            e = exp_q.pop_front();
            if (int'(sine_out) != e.value || e.edge_no != edge_cnt) begin
              errors++;
              $display("FAIL sample: got %0d at edge %0d, required %0d at edge %0d",
                       sine_out, edge_cnt, e.value, e.edge_no);
            end else begin
              $display("sample edge=%0d value=%0d ok", edge_cnt, sine_out);
            end
          end
          prev_out = sine_out;
        end
        while (exp_q.size() > 0 && exp_q[0].edge_no <= edge_cnt) begin
          e = exp_q.pop_front();
          checks++;
          errors++;
          $display("FAIL missed_sample: sine_out=%0d at edge %0d, required %0d at edge %0d",
                   sine_out, edge_cnt, e.value, e.edge_no);
        end
      end
    end
  end

  // Apply one configuration for n clock edges and predict its samples.
  // Ticks come (thr - count + 1) edges after the segment start, or on the
  // first edge if the count already reached thr, then every thr+1 edges;
  // each new sample shows one edge after its tick.
  task automatic run_seg(input logic sw, input logic [7:0] hi, input logic [7:0] lo, input int n);
    int   t;
    int   d;
    int   last;
    int   e0;
    exp_t item;
    t    = sw ? int'(hi) : int'(lo);
    e0   = edge_cnt;
    sw0                 = sw;
    div_factor_freqhigh = hi;
    div_factor_freqlow  = lo;
    d    = (m_cnt >= t) ? 1 : (t - m_cnt + 1);
    last = -1;
    for (int e = d; e <= n; e += t + 1) begin
      m_phase      = (m_phase + 1) % 256;
      item.edge_no = e0 + e + 1;
      item.value   = lut_ref(m_phase);
      exp_q.push_back(item);
      last = e;
    end
    if (last < 0) m_cnt = m_cnt + n;
    else          m_cnt = n - last;
    $display("segment sw0=%0d high=%0d low=%0d edges=%0d start_edge=%0d", sw, hi, lo, n, e0);
    repeat (n) @(posedge clk_in);
    @(negedge clk_in);
    #2;
  endtask

  // Assert reset between clock edges, confirm the output clears at once.
  task automatic do_reset(input int hold);
    rst_n = 1'b0;
    #1;
    checks++;
    if (sine_out !== 12'd2048) begin
      errors++;
      $display("FAIL async_reset: sine_out=%0d required 2048 before any clock edge", sine_out);
    end else begin
      $display("reset asserted, sine_out=%0d", sine_out);
    end
    exp_q.delete();
    m_cnt   = 0;
    m_phase = 0;
    repeat (hold) @(negedge clk_in);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n               = 1'b0;
    sw0                 = 1'b0;
    div_factor_freqhigh = 8'd55;
    div_factor_freqlow  = 8'd195;
    @(negedge clk_in);
    #2;
    do_reset(4);

    // Low rate over more than a full period, then switch to high rate.
    obs_max = 0;
    obs_min = 4096;
    run_seg(1'b0, 8'd55, 8'd195, 55000);
    checks++;
    if (obs_max != 4095) begin
      errors++;
      $display("FAIL peak: observed %0d required 4095", obs_max);
    end
    checks++;
    if (obs_min != 1) begin
      errors++;
      $display("FAIL trough: observed %0d required 1", obs_min);
    end
    run_seg(1'b1, 8'd55, 8'd195, 15000);

    // Threshold 0: one new sample per clock, through the 255 -> 0 wrap.
    run_seg(1'b0, 8'd55, 8'd0, 300);

    // Randomized select and threshold changes mid-count.
    for (int i = 0; i < 12; i++) begin
      run_seg(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
              8'($urandom_range(0, 15)), int'($urandom_range(20, 400)));
    end

    // Walk to phase 100, reset asynchronously, then check the restart.
    do_reset(2);
    run_seg(1'b0, 8'd55, 8'd1, 200);
    do_reset(3);
    run_seg(1'b0, 8'd55, 8'd195, 400);

    repeat (3) @(negedge clk_in);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d samples still outstanding, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
